// File: rtl/spi_serializer_pkg.sv
// Shared definitions for the SPI transmit serializer: FSM state encoding,
// parameter defaults and the output-bit selection helper.
package spi_serializer_pkg;

    // Two-state transmit FSM: waiting for a word, or shifting a frame out.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_BUS_WIDTH  = 8;
    localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

    // Picks the bit that sits at the output end of the shift register.
    function automatic logic select_out(input logic msb_first,
                                        input logic top_bit,
                                        input logic bottom_bit);
        logic result;
        if (msb_first) begin
            result = top_bit;
        end else begin
            result = bottom_bit;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_serializer_if.sv
// Parallel handshake plus serial-side signals of the SPI transmit serializer.
// The master side supplies words and shift strobes; the slave side is the serializer.
interface spi_serializer_if
    import spi_serializer_pkg::*;
#(
    parameter int bus_width = DEFAULT_BUS_WIDTH
);
    logic [bus_width-1:0] p_data;
    logic                 p_valid;
    logic                 p_ready;
    logic                 enable;
    logic                 s_data;
    logic                 busy;
    logic                 done;

    modport master (
        output p_data, p_valid, enable,
        input  p_ready, s_data, busy, done
    );

    modport slave (
        input  p_data, p_valid, enable,
        output p_ready, s_data, busy, done
    );
endinterface

// File: rtl/spi_tx_holdbuf.sv
// One-entry hold buffer for the SPI transmit serializer. A word offered while
// a frame is shifting is parked here and handed to the shift register on the
// last-bit strobe, so consecutive frames run with no gap bit.
module spi_tx_holdbuf
    import spi_serializer_pkg::*;
#(
    parameter int bus_width = DEFAULT_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [bus_width-1:0] load_data,
    input  logic                 drain,
    output logic [bus_width-1:0] data,
    output logic                 full
);

    logic [bus_width-1:0] data_r;
    logic                 full_r;

    // Capture a word on load, release the full flag on drain; load wins because
    // the top never asks for both in one cycle (p_ready is low while full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {bus_width{1'b0}};
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= load_data;
            full_r <= 1'b1;
        end else if (drain) begin
            full_r <= 1'b0;
        end
    end

    assign data = data_r;
    assign full = full_r;

endmodule

// File: rtl/spi_serializer.sv
// SPI transmit serializer: accepts parallel words over valid/ready and shifts
// them out one bit per enable strobe. A one-entry hold buffer (or a direct
// bypass on the last-bit strobe) keeps consecutive frames contiguous.
module spi_serializer
    import spi_serializer_pkg::*;
#(
    parameter int   bus_width   = DEFAULT_BUS_WIDTH,
    parameter int   counter_reg = $clog2(bus_width),
    parameter int   MSB_FIRST   = 1,
    parameter logic IDLE_LEVEL  = DEFAULT_IDLE_LEVEL
) (
    input logic              clk,
    input logic              rst,
    spi_serializer_if.slave  bus
);

    localparam logic [counter_reg-1:0] LAST_COUNT = counter_reg'(bus_width - 1);
    localparam logic [counter_reg-1:0] ONE_COUNT  = counter_reg'(1);
    localparam logic                   MSB_SEL    = (MSB_FIRST != 0);

    state_t               state_r;
    logic [counter_reg-1:0] counter_r;
    logic [bus_width-1:0] sreg_r;
    logic                 done_r;

    logic [bus_width-1:0] hold_data_s;
    logic                 hold_full_s;
    logic                 accept_s;
    logic                 last_strobe_s;
    logic                 hold_load_s;
    logic                 hold_drain_s;
    logic [bus_width-1:0] shifted_s;
    logic                 s_data_s;

    spi_tx_holdbuf #(
        .bus_width (bus_width)
    ) u_holdbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load_s),
        .load_data (bus.p_data),
        .drain     (hold_drain_s),
        .data      (hold_data_s),
        .full      (hold_full_s)
    );

    // Handshake and hold-buffer control; p_ready depends only on the hold flag.
    always_comb begin
        accept_s      = bus.p_valid & ~hold_full_s;
        last_strobe_s = (state_r == ST_SHIFT) & bus.enable & (counter_r == LAST_COUNT);
        hold_drain_s  = last_strobe_s & hold_full_s;
        hold_load_s   = (state_r == ST_SHIFT) & accept_s & ~last_strobe_s;
    end

    // Next shift-register value: move every bit one place toward the output end.
    always_comb begin
        if (MSB_SEL) begin
            shifted_s = {sreg_r[bus_width-2:0], 1'b0};
        end else begin
            shifted_s = {1'b0, sreg_r[bus_width-1:1]};
        end
    end

    // Transmit FSM with bit counter, shift register and the registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            counter_r <= {counter_reg{1'b0}};
            sreg_r    <= {bus_width{1'b0}};
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // enable is deliberately ignored here
                    if (accept_s) begin
                        sreg_r    <= bus.p_data;
                        counter_r <= {counter_reg{1'b0}};
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.enable) begin
                        if (counter_r == LAST_COUNT) begin
                            done_r    <= 1'b1;
                            counter_r <= {counter_reg{1'b0}};
                            if (hold_full_s) begin
                                sreg_r <= hold_data_s;
                            end else if (accept_s) begin
                                sreg_r <= bus.p_data;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            sreg_r    <= shifted_s;
                            counter_r <= counter_r + ONE_COUNT;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    counter_r <= {counter_reg{1'b0}};
                end
            endcase
        end
    end

    // Serial output decoded purely from flops; idle level outside a frame.
    always_comb begin
        if (state_r == ST_SHIFT) begin
            s_data_s = select_out(MSB_SEL, sreg_r[bus_width-1], sreg_r[0]);
        end else begin
            s_data_s = IDLE_LEVEL;
        end
    end

    assign bus.s_data  = s_data_s;
    assign bus.p_ready = ~hold_full_s;
    assign bus.busy    = (state_r == ST_SHIFT);
    assign bus.done    = done_r;

endmodule

// File: tb/tb_spi_serializer.sv
// Self-checking bench for spi_serializer: directed scenarios plus a randomized
// loopback against a word-level reference model.
module tb_spi_serializer;

    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_serializer_if #(.bus_width(BW)) if_m ();
    spi_serializer_if #(.bus_width(BW)) if_l ();

    spi_serializer #(.bus_width(BW), .counter_reg(3), .MSB_FIRST(1), .IDLE_LEVEL(1'b0))
        dut_msb (.clk(clk), .rst(rst), .bus(if_m));

    spi_serializer #(.bus_width(BW), .counter_reg(3), .MSB_FIRST(0), .IDLE_LEVEL(1'b0))
        dut_lsb (.clk(clk), .rst(rst), .bus(if_l));

    int checks = 0;
    int errors = 0;

    // Reference model state: bits the receiver would sample and words accepted.
    logic       bits_q[$];
    logic [7:0] sent_q[$];
    logic       last_done;

    // One clock of stimulus on the MSB-first instance; records what the receiver
    // samples on the coming edge and whether the word is accepted.
    task automatic tick(input logic v, input logic [7:0] d, input logic en, output logic acc);
        if_m.p_valid = v;
        if_m.p_data  = d;
        if_m.enable  = en;
        @(negedge clk);
        if (en && if_m.busy) bits_q.push_back(if_m.s_data);
        acc = v && if_m.p_ready;
        if (acc) sent_q.push_back(d);
        @(posedge clk);
        #1;
        last_done = if_m.done;
    endtask

    function automatic logic [15:0] stream16();
        logic [15:0] r = 16'h0000;
        for (int k = 0; k < 16; k++) r = {r[14:0], bits_q[k]};
        return r;
    endfunction

    task automatic test_reset();
        logic acc;
        rst = 1'b1;
        if_m.p_valid = 1'b0; if_m.p_data = 8'h00; if_m.enable = 1'b0;
        if_l.p_valid = 1'b0; if_l.p_data = 8'h00; if_l.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if_m.p_ready !== 1'b1) begin errors++; $display("FAIL reset_p_ready: got %b expected 1", if_m.p_ready); end
        checks++; if (if_m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if_m.busy); end
        checks++; if (if_m.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", if_m.done); end
        checks++; if (if_m.s_data !== 1'b0) begin errors++; $display("FAIL reset_s_data: got %b expected 0", if_m.s_data); end
        checks++; if (if_l.s_data !== 1'b0 || if_l.busy !== 1'b0) begin errors++; $display("FAIL reset_lsb: s_data %b busy %b expected 0 0", if_l.s_data, if_l.busy); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b1, acc);
            checks++; if (if_m.busy !== 1'b0 || if_m.s_data !== 1'b0) begin errors++; $display("FAIL idle_enable_ignored: busy %b s_data %b expected 0 0", if_m.busy, if_m.s_data); end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] w = 8'hA5;
        logic acc;
        int dones = 0;
        bits_q.delete(); sent_q.delete();
        tick(1'b1, w, 1'b0, acc);
        checks++; if (if_m.busy !== 1'b1 || if_m.s_data !== w[7]) begin errors++; $display("FAIL single_first_bit: busy %b s_data %b expected 1 %b", if_m.busy, if_m.s_data, w[7]); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00, 1'b0, acc);
            dones += int'(last_done);
            tick(1'b0, 8'h00, 1'b1, acc);
            dones += int'(last_done);
            if (i < 7) begin
                checks++; if (if_m.busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: strobe %0d got %b expected 1", i, if_m.busy); end
            end
        end
        checks++; if (if_m.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", if_m.busy); end
        checks++; if (last_done !== 1'b1) begin errors++; $display("FAIL single_done_after_last: got %b expected 1", last_done); end
        tick(1'b0, 8'h00, 1'b0, acc);
        dones += int'(last_done);
        checks++; if (last_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", last_done); end
        checks++; if (dones != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", dones); end
        checks++;
        if (bits_q.size() != 8) begin
            errors++; $display("FAIL single_bit_count: got %0d expected 8", bits_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (bits_q[k] !== w[7-k]) begin errors++; $display("FAIL single_bit: index %0d got %b expected %b", k, bits_q[k], w[7-k]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0 = 8'h3C;
        logic [7:0] w1 = 8'hC3;
        logic acc;
        int dones = 0;
        int busy_low = 0;
        bits_q.delete(); sent_q.delete();
        tick(1'b1, w0, 1'b0, acc);
        tick(1'b1, w1, 1'b0, acc);
        checks++; if (acc !== 1'b1 || if_m.p_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_load: accepted %b p_ready %b expected 1 0", acc, if_m.p_ready); end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 8'h00, 1'b1, acc);
            dones += int'(last_done);
            if (i < 15 && if_m.busy !== 1'b1) busy_low++;
            if (i == 7) begin
                checks++; if (if_m.p_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_return: got %b expected 1", if_m.p_ready); end
            end
        end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL b2b_busy_window: low cycles %0d expected 0", busy_low); end
        checks++; if (if_m.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", if_m.busy); end
        checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
        checks++;
        if (bits_q.size() != 16) begin
            errors++; $display("FAIL b2b_bit_count: got %0d expected 16", bits_q.size());
        end else if (stream16() !== {w0, w1}) begin
            errors++; $display("FAIL b2b_stream: got %h expected %h", stream16(), {w0, w1});
        end
    endtask

    task automatic test_bypass();
        logic acc;
        int dones = 0;
        int ready_low = 0;
        bits_q.delete(); sent_q.delete();
        tick(1'b1, 8'hFF, 1'b0, acc);
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 8'h00, 1'b1, acc);
            if (if_m.p_ready !== 1'b1) ready_low++;
        end
        tick(1'b1, 8'h81, 1'b1, acc);
        dones += int'(last_done);
        checks++; if (acc !== 1'b1 || if_m.busy !== 1'b1) begin errors++; $display("FAIL bypass_accept: accepted %b busy %b expected 1 1", acc, if_m.busy); end
        for (int i = 0; i < 8; i++) begin
            if (if_m.p_ready !== 1'b1) ready_low++;
            tick(1'b0, 8'h00, 1'b1, acc);
            dones += int'(last_done);
        end
        checks++; if (ready_low != 0) begin errors++; $display("FAIL bypass_hold_filled: p_ready low %0d times expected 0", ready_low); end
        checks++; if (dones != 2 || if_m.busy !== 1'b0) begin errors++; $display("FAIL bypass_done: dones %0d busy %b expected 2 0", dones, if_m.busy); end
        checks++;
        if (bits_q.size() != 16) begin
            errors++; $display("FAIL bypass_bit_count: got %0d expected 16", bits_q.size());
        end else if (stream16() !== 16'hFF81) begin
            errors++; $display("FAIL bypass_stream: got %h expected ff81", stream16());
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] words[2];
        words[0] = 8'h01;
        words[1] = 8'($urandom);
        for (int n = 0; n < 2; n++) begin
            if_l.p_valid = 1'b1;
            if_l.p_data  = words[n];
            if_l.enable  = 1'b0;
            @(posedge clk); #1;
            if_l.p_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if_l.enable = 1'b1;
                @(negedge clk);
                checks++; if (if_l.s_data !== words[n][i] || if_l.busy !== 1'b1) begin errors++; $display("FAIL lsb_bit: word %h strobe %0d s_data %b busy %b expected %b 1", words[n], i, if_l.s_data, if_l.busy, words[n][i]); end
                @(posedge clk); #1;
            end
            if_l.enable = 1'b0;
            checks++; if (if_l.done !== 1'b1 || if_l.busy !== 1'b0) begin errors++; $display("FAIL lsb_end: done %b busy %b expected 1 0", if_l.done, if_l.busy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w3 = 8'($urandom);
        logic acc;
        int dones = 0;
        tick(1'b1, 8'($urandom), 1'b0, acc);
        tick(1'b1, 8'($urandom), 1'b0, acc);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, acc);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (if_m.s_data !== 1'b0 || if_m.p_ready !== 1'b1 || if_m.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_immediate: s_data %b p_ready %b busy %b expected 0 1 0", if_m.s_data, if_m.p_ready, if_m.busy); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bits_q.delete(); sent_q.delete();
        tick(1'b1, w3, 1'b0, acc);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00, 1'b1, acc);
            dones += int'(last_done);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00, 1'b1, acc);
            dones += int'(last_done);
        end
        checks++; if (dones != 1 || if_m.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_held_dropped: dones %0d busy %b expected 1 0", dones, if_m.busy); end
        checks++;
        if (bits_q.size() != 8) begin
            errors++; $display("FAIL reset_mid_bit_count: got %0d expected 8", bits_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (bits_q[k] !== w3[7-k]) begin errors++; $display("FAIL reset_mid_bit: index %0d got %b expected %b", k, bits_q[k], w3[7-k]); end
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] pw = 8'h00;
        logic [7:0] got;
        logic [7:0] exp;
        logic have = 1'b0;
        logic en;
        logic acc;
        int frames = 0;
        int cycles = 0;
        bits_q.delete(); sent_q.delete();
        while (frames < 1000 && cycles < 60000) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                pw = 8'($urandom);
                have = 1'b1;
            end
            en = ($urandom_range(0, 2) == 0);
            tick(have, pw, en, acc);
            if (acc) have = 1'b0;
            cycles++;
            if (last_done) begin
                frames++;
                checks++;
                if (bits_q.size() < 8 || sent_q.size() == 0) begin
                    errors++; $display("FAIL loopback_underflow: frame %0d bits %0d words %0d", frames, bits_q.size(), sent_q.size());
                end else begin
                    got = 8'h00;
                    for (int k = 0; k < 8; k++) got = {got[6:0], bits_q.pop_front()};
                    exp = sent_q.pop_front();
                    if (got !== exp) begin errors++; $display("FAIL loopback_word: frame %0d got %h expected %h", frames, got, exp); end
                end
            end
        end
        checks++; if (frames != 1000) begin errors++; $display("FAIL loopback_timeout: frames %0d expected 1000 within budget", frames); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bypass();
        test_lsb_first();
        test_reset_mid_frame();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
